// File: rtl/alct_link_startup.sv
// ALCT-to-TMB link bring-up: waits for ALCT startup, requests and qualifies the sync pattern, then monitors the link.
// Optional debug build via ALCT_LINK_DEBUG_EN: 5-clock msec timebase plus state-name and run-counter outputs.
module alct_link_startup #(
    parameter logic [27:0] SYNC_PATTERN = 28'h2AAAAAA,
    parameter int          MSEC_CLKS    = 40078,
    parameter int          SETTLE_MSEC  = 2,
    parameter int          GOOD_WORDS   = 16,
    parameter int          TIMEOUT_MSEC = 10,
    parameter int          BAD_WORDS    = 4,
    parameter int          MAX_RETRY    = 3
) (
    input  logic        clock,
    input  logic        global_reset,
    input  logic        alct_startup_done,
    input  logic        alct_rx_valid,
    input  logic [27:0] alct_rx_data,
    input  logic        link_reinit,
    output logic        alct_sync_req,
    output logic        alct_link_up,
    output logic        alct_link_fail,
    output logic [1:0]  alct_retry_cnt,
    output logic [7:0]  alct_lost_cnt
`ifdef ALCT_LINK_DEBUG_EN
    ,
    output logic [39:0] alct_link_sm_dsp,
    output logic [7:0]  run_cnt
`endif
);

`ifdef ALCT_LINK_DEBUG_EN
    localparam int MSEC_EFF = 5;
`else
    localparam int MSEC_EFF = MSEC_CLKS;
`endif

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SETTLE = 3'd1,
        S_CHECK  = 3'd2,
        S_RETRY  = 3'd3,
        S_LINKUP = 3'd4,
        S_FAILED = 3'd5
    } state_t;

    state_t      r_state, w_state_next;
    logic        r_done_ff, r_valid_ff;
    logic [27:0] r_data_ff;
    logic [15:0] r_msec_clk, r_msec_cnt, w_msec_now;
    logic [7:0]  r_run_cnt, w_run_upd, r_lost_cnt;
    logic [1:0]  r_retry_cnt, w_retry_plus;
    logic        w_msec_tick, w_match, w_miss, w_state_chg, w_retry_inc, w_lost_inc;
    logic        r_sync_req, r_link_up, r_link_fail;

    assign w_match      = r_valid_ff && (r_data_ff == SYNC_PATTERN);
    assign w_miss       = r_valid_ff && !w_match;
    assign w_msec_tick  = (r_msec_clk == 16'(MSEC_EFF - 1));
    // Msec count including this clock's pulse, so a dwell of N msec is exactly N*MSEC_EFF clocks
    assign w_msec_now   = r_msec_cnt + {15'd0, w_msec_tick};
    assign w_retry_plus = r_retry_cnt + 2'd1;
    assign w_state_chg  = (w_state_next != r_state);

    always_comb begin
        w_state_next = r_state;
        w_run_upd    = r_run_cnt;
        w_retry_inc  = 1'b0;
        w_lost_inc   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_done_ff) w_state_next = S_SETTLE;
            end
            S_SETTLE: begin
                if (w_msec_now == 16'(SETTLE_MSEC)) w_state_next = S_CHECK;
            end
            S_CHECK: begin
                if (w_match)     w_run_upd = r_run_cnt + 8'd1;
                else if (w_miss) w_run_upd = 8'd0;
                if (w_run_upd == 8'(GOOD_WORDS))           w_state_next = S_LINKUP;
                else if (w_msec_now == 16'(TIMEOUT_MSEC))  w_state_next = S_RETRY;
            end
            S_RETRY: begin
                w_retry_inc  = 1'b1;
                w_state_next = (w_retry_plus == 2'(MAX_RETRY)) ? S_FAILED : S_SETTLE;
            end
            S_LINKUP: begin
                if (w_miss)       w_run_upd = r_run_cnt + 8'd1;
                else if (w_match) w_run_upd = 8'd0;
                if (w_run_upd == 8'(BAD_WORDS)) begin
                    w_lost_inc   = 1'b1;
                    w_state_next = S_SETTLE;
                end
            end
            S_FAILED: w_state_next = S_FAILED;
            default:  w_state_next = S_IDLE;
        endcase
        // Loss of ALCT configuration, then VME reinit, override every other transition
        if (r_state != S_IDLE && !r_done_ff) begin
            w_state_next = S_IDLE;
            w_retry_inc  = 1'b0;
            w_lost_inc   = 1'b0;
        end
        if (link_reinit) begin
            w_state_next = S_IDLE;
            w_retry_inc  = 1'b0;
            w_lost_inc   = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge global_reset) begin
        if (global_reset) begin
            r_done_ff   <= 1'b0;
            r_valid_ff  <= 1'b0;
            r_data_ff   <= 28'd0;
            r_state     <= S_IDLE;
            r_msec_clk  <= 16'd0;
            r_msec_cnt  <= 16'd0;
            r_run_cnt   <= 8'd0;
            r_retry_cnt <= 2'd0;
            r_lost_cnt  <= 8'd0;
            r_sync_req  <= 1'b0;
            r_link_up   <= 1'b0;
            r_link_fail <= 1'b0;
        end else begin
            r_done_ff  <= alct_startup_done;
            r_valid_ff <= alct_rx_valid;
            r_data_ff  <= alct_rx_data;
            r_state    <= w_state_next;
            if (w_state_chg) begin
                r_msec_clk <= 16'd0;
                r_msec_cnt <= 16'd0;
                r_run_cnt  <= 8'd0;
            end else begin
                r_msec_clk <= w_msec_tick ? 16'd0 : r_msec_clk + 16'd1;
                r_msec_cnt <= w_msec_now;
                r_run_cnt  <= w_run_upd;
            end
            if (link_reinit)      r_retry_cnt <= 2'd0;
            else if (w_retry_inc) r_retry_cnt <= w_retry_plus;
            if (w_lost_inc && r_lost_cnt != 8'hFF) r_lost_cnt <= r_lost_cnt + 8'd1;
            r_sync_req  <= (r_state == S_CHECK);
            r_link_up   <= (r_state == S_LINKUP);
            r_link_fail <= (r_state == S_FAILED);
        end
    end

    assign alct_sync_req  = r_sync_req;
    assign alct_link_up   = r_link_up;
    assign alct_link_fail = r_link_fail;
    assign alct_retry_cnt = r_retry_cnt;
    assign alct_lost_cnt  = r_lost_cnt;

`ifdef ALCT_LINK_DEBUG_EN
    always_comb begin
        alct_link_sm_dsp = "idle ";
        case (r_state)
            S_SETTLE: alct_link_sm_dsp = "settl";
            S_CHECK:  alct_link_sm_dsp = "check";
            S_RETRY:  alct_link_sm_dsp = "retry";
            S_LINKUP: alct_link_sm_dsp = "linku";
            S_FAILED: alct_link_sm_dsp = "fail ";
            default:  alct_link_sm_dsp = "idle ";
        endcase
    end
    assign run_cnt = r_run_cnt;
`endif

endmodule

// File: tb/tb_alct_link_startup.sv
// Self-checking bench for alct_link_startup: stream-scan reference model for link qualification,
// timing formulas for settle/timeout/retry, plus reinit, link-loss, done-drop and async reset scenarios.
module tb_alct_link_startup;
    localparam logic [27:0] SYNC = 28'h2AAAAAA;
    localparam int MSEC    = 5;
    localparam int SETTLE  = 2;
    localparam int GOOD    = 16;
    localparam int TIMEOUT = 10;
    localparam int BAD     = 4;
    localparam int MAXR    = 3;
    // done presented at index 0: input FF + settle dwell + 2 clocks
    localparam int SYNC_LAT = 1 + SETTLE * MSEC + 2;

    logic        clock = 1'b0;
    logic        global_reset = 1'b1;
    logic        alct_startup_done = 1'b0;
    logic        alct_rx_valid = 1'b0;
    logic [27:0] alct_rx_data = 28'd0;
    logic        link_reinit = 1'b0;
    logic        alct_sync_req, alct_link_up, alct_link_fail;
    logic [1:0]  alct_retry_cnt;
    logic [7:0]  alct_lost_cnt;
`ifdef ALCT_LINK_DEBUG_EN
    logic [39:0] dbg_dsp;
    logic [7:0]  dbg_run;
`endif

    int checks = 0;
    int errors = 0;
    logic [28:0] stream[$];

    always #5 clock = ~clock;

    alct_link_startup #(.MSEC_CLKS(MSEC)) dut (
        .clock(clock), .global_reset(global_reset), .alct_startup_done(alct_startup_done),
        .alct_rx_valid(alct_rx_valid), .alct_rx_data(alct_rx_data), .link_reinit(link_reinit),
        .alct_sync_req(alct_sync_req), .alct_link_up(alct_link_up), .alct_link_fail(alct_link_fail),
        .alct_retry_cnt(alct_retry_cnt), .alct_lost_cnt(alct_lost_cnt)
`ifdef ALCT_LINK_DEBUG_EN
        , .alct_link_sm_dsp(dbg_dsp), .run_cnt(dbg_run)
`endif
    );

    // Drive one word at the current falling edge, return at the next falling edge
    task automatic step(input logic v, input logic [27:0] d);
        alct_rx_valid = v;
        alct_rx_data  = d;
        @(negedge clock);
    endtask

    task automatic do_reset();
        global_reset = 1'b1;
        alct_startup_done = 1'b0;
        link_reinit = 1'b0;
        alct_rx_valid = 1'b0;
        alct_rx_data = 28'd0;
        repeat (3) @(negedge clock);
        global_reset = 1'b0;
        @(negedge clock);
    endtask

    function automatic logic [27:0] junk();
        logic [27:0] d;
        d = 28'($urandom);
        if (d == SYNC) d = d ^ 28'h1;
        return d;
    endfunction

    // Raise done at index 0, play the stream, record first sample index of sync_req and link_up
    task automatic play_stream(input int budget, output int sync_rise, output int link_rise);
        sync_rise = -1;
        link_rise = -1;
        alct_startup_done = 1'b1;
        for (int j = 0; j < budget && link_rise < 0; j++) begin
            if (j < stream.size()) step(stream[j][28], stream[j][27:0]);
            else                   step(1'b0, 28'd0);
            if (sync_rise < 0 && alct_sync_req) sync_rise = j + 1;
            if (link_rise < 0 && alct_link_up)  link_rise = j + 1;
        end
    endtask

    // Words presented inside the check window count; the last of GOOD consecutive valid
    // matches needs input FF, evaluation and a registered output: link_up 3 samples later.
    function automatic int predict_link();
        int run = 0;
        int lo = SETTLE * MSEC + 1;
        int hi = SETTLE * MSEC + TIMEOUT * MSEC;
        for (int j = lo; j <= hi; j++) begin
            if (j < stream.size() && stream[j][28]) begin
                if (stream[j][27:0] == SYNC) run++;
                else                         run = 0;
                if (run == GOOD) return j + 3;
            end
        end
        return -1;
    endfunction

    task automatic fill_sync(input int n);
        stream.delete();
        for (int i = 0; i < n; i++) stream.push_back({1'b1, SYNC});
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({alct_sync_req, alct_link_up, alct_link_fail, alct_retry_cnt, alct_lost_cnt} !== 13'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected 0",
                     {alct_sync_req, alct_link_up, alct_link_fail, alct_retry_cnt, alct_lost_cnt});
        end
        $display("test_reset done");
    endtask

    task automatic test_bringup_basic();
        int s, l, exp_l;
        do_reset();
        fill_sync(60);
        exp_l = predict_link();
        play_stream(150, s, l);
        checks++;
        if (s !== SYNC_LAT) begin errors++; $display("FAIL basic_sync_req_rise: got %0d expected %0d", s, SYNC_LAT); end
        checks++;
        if (l !== exp_l) begin errors++; $display("FAIL basic_link_up_rise: got %0d expected %0d", l, exp_l); end
        checks++;
        if (alct_retry_cnt !== 2'd0) begin errors++; $display("FAIL basic_retry_cnt: got %0d expected 0", alct_retry_cnt); end
`ifdef ALCT_LINK_DEBUG_EN
        begin
            logic [39:0] exp_dsp;
            exp_dsp = "linku";
            checks++;
            if (dbg_dsp !== exp_dsp) begin errors++; $display("FAIL basic_sm_dsp: got %h expected %h", dbg_dsp, exp_dsp); end
        end
`endif
        $display("test_bringup_basic: sync_req at %0d, link_up at %0d", s, l);
    endtask

    task automatic test_mismatch_run();
        int s, l, exp_l;
        do_reset();
        stream.delete();
        for (int i = 0; i < SETTLE * MSEC + 1; i++) stream.push_back({1'b0, 28'd0});
        for (int i = 0; i < GOOD - 1; i++) stream.push_back({1'b1, SYNC});
        stream.push_back({1'b1, junk()});
        for (int i = 0; i < GOOD; i++) stream.push_back({1'b1, SYNC});
        exp_l = predict_link();
        play_stream(150, s, l);
        checks++;
        if (l !== exp_l) begin errors++; $display("FAIL mismatch_link_up_rise: got %0d expected %0d", l, exp_l); end
        checks++;
        if (alct_retry_cnt !== 2'd0) begin errors++; $display("FAIL mismatch_retry_cnt: got %0d expected 0", alct_retry_cnt); end
        $display("test_mismatch_run: link_up at %0d", l);
    endtask

    task automatic test_alt_valid();
        int s, l, exp_l;
        do_reset();
        stream.delete();
        for (int i = 0; i < SETTLE * MSEC + 1; i++) stream.push_back({1'b0, SYNC});
        for (int k = 0; k < 2 * GOOD; k++) begin
            if (k % 2 == 0)      stream.push_back({1'b1, SYNC});
            else if (k % 4 == 1) stream.push_back({1'b0, SYNC});
            else                 stream.push_back({1'b0, junk()});
        end
        exp_l = predict_link();
        play_stream(150, s, l);
        checks++;
        if (l !== exp_l) begin errors++; $display("FAIL alt_valid_link_up_rise: got %0d expected %0d", l, exp_l); end
        checks++;
        if (s !== SYNC_LAT) begin errors++; $display("FAIL alt_valid_sync_req_rise: got %0d expected %0d", s, SYNC_LAT); end
        $display("test_alt_valid: link_up at %0d", l);
    endtask

    task automatic test_random();
        int s, l, exp_l;
        for (int it = 0; it < 4; it++) begin
            do_reset();
            do begin
                stream.delete();
                for (int i = 0; i < SETTLE * MSEC + 1 + 48; i++) begin
                    logic v;
                    logic [27:0] d;
                    v = ($urandom % 4) != 0;
                    d = (($urandom % 8) != 0) ? SYNC : 28'($urandom);
                    stream.push_back({v, d});
                end
                exp_l = predict_link();
            end while (exp_l < 0);
            play_stream(150, s, l);
            checks++;
            if (s !== SYNC_LAT) begin errors++; $display("FAIL random_sync_req_rise[%0d]: got %0d expected %0d", it, s, SYNC_LAT); end
            checks++;
            if (l !== exp_l) begin errors++; $display("FAIL random_link_up_rise[%0d]: got %0d expected %0d", it, l, exp_l); end
            $display("test_random[%0d]: link_up at %0d (model %0d)", it, l, exp_l);
        end
    endtask

    task automatic test_retry_fail();
        int r_at[1:3];
        int f_at, exp_r, rel, s;
        do_reset();
        r_at[1] = -1; r_at[2] = -1; r_at[3] = -1; f_at = -1;
        alct_startup_done = 1'b1;
        for (int j = 0; j < 230; j++) begin
            step(1'b1, junk());
            for (int k = 1; k <= 3; k++)
                if (r_at[k] < 0 && alct_retry_cnt == 2'(k)) r_at[k] = j + 1;
            if (f_at < 0 && alct_link_fail) f_at = j + 1;
        end
        for (int k = 1; k <= MAXR; k++) begin
            // each failed attempt costs settle + timeout + one retry clock
            exp_r = 2 + k * (SETTLE * MSEC + TIMEOUT * MSEC + 1);
            checks++;
            if (r_at[k] !== exp_r) begin errors++; $display("FAIL retry_cnt_%0d_time: got %0d expected %0d", k, r_at[k], exp_r); end
        end
        exp_r = 2 + MAXR * (SETTLE * MSEC + TIMEOUT * MSEC + 1) + 1;
        checks++;
        if (f_at !== exp_r) begin errors++; $display("FAIL link_fail_rise: got %0d expected %0d", f_at, exp_r); end
        checks++;
        if ({alct_link_fail, alct_retry_cnt, alct_sync_req} !== {1'b1, 2'd3, 1'b0}) begin
            errors++;
            $display("FAIL failed_hold: got fail=%b retry=%0d sync=%b expected fail=1 retry=3 sync=0",
                     alct_link_fail, alct_retry_cnt, alct_sync_req);
        end
        link_reinit = 1'b1;
        step(1'b0, 28'd0);
        link_reinit = 1'b0;
        checks++;
        if (alct_retry_cnt !== 2'd0) begin errors++; $display("FAIL reinit_retry_clear: got %0d expected 0", alct_retry_cnt); end
        step(1'b0, 28'd0);
        checks++;
        if (alct_link_fail !== 1'b0) begin errors++; $display("FAIL reinit_link_fail: got %b expected 0", alct_link_fail); end
        s = -1;
        for (rel = 3; rel < 40 && s < 0; rel++) begin
            step(1'b0, 28'd0);
            if (alct_sync_req) s = rel;
        end
        checks++;
        if (s !== SYNC_LAT) begin errors++; $display("FAIL reinit_sync_req_rise: got %0d expected %0d", s, SYNC_LAT); end
        $display("test_retry_fail: retries at %0d %0d %0d, fail at %0d", r_at[1], r_at[2], r_at[3], f_at);
    endtask

    // Leaves the DUT in check (sync_req=1) with lost_cnt=1 for the following scenarios
    task automatic test_link_lost();
        int s, l, q, down_at, lost_at, sync_at, exp_l;
        logic [3:0] pat;
        do_reset();
        fill_sync(60);
        exp_l = predict_link();
        play_stream(150, s, l);
        checks++;
        if (l !== exp_l) begin errors++; $display("FAIL lost_setup_link_up: got %0d expected %0d", l, exp_l); end
        pat = 4'b1000;
        down_at = -1; lost_at = -1; sync_at = -1;
        q = l + 3 + 1 + BAD - 1;
        for (int t = 0; t < 3 + 1 + BAD + 16; t++) begin
            if (t < 3 || (t >= 4 && t < 4 + BAD)) step(1'b1, junk());
            else if (t == 3)                      step(1'b1, SYNC);
            else                                  step(1'b0, 28'd0);
            if (down_at < 0 && !alct_link_up)         down_at = l + t + 1;
            if (lost_at < 0 && alct_lost_cnt == 8'd1) lost_at = l + t + 1;
            if (sync_at < 0 && down_at >= 0 && alct_sync_req) sync_at = l + t + 1;
        end
        checks++;
        if (lost_at !== q + 2) begin errors++; $display("FAIL lost_cnt_time: got %0d expected %0d", lost_at, q + 2); end
        checks++;
        if (down_at !== q + 3) begin errors++; $display("FAIL link_up_drop_time: got %0d expected %0d", down_at, q + 3); end
        checks++;
        if (sync_at !== q + 2 + SETTLE * MSEC + 1) begin
            errors++; $display("FAIL lost_resettle_sync: got %0d expected %0d", sync_at, q + 2 + SETTLE * MSEC + 1);
        end
        checks++;
        if ({alct_lost_cnt, alct_retry_cnt} !== {8'd1, 2'd0}) begin
            errors++; $display("FAIL lost_counts: got lost=%0d retry=%0d expected lost=1 retry=0", alct_lost_cnt, alct_retry_cnt);
        end
        $display("test_link_lost: lost at %0d, link_up low at %0d (pattern %b)", lost_at, down_at, pat);
    endtask

    task automatic test_done_drop();
        alct_startup_done = 1'b0;
        step(1'b0, 28'd0);
        step(1'b0, 28'd0);
        checks++;
        if (alct_sync_req !== 1'b1) begin errors++; $display("FAIL done_drop_sync_lag: got %b expected 1", alct_sync_req); end
        step(1'b0, 28'd0);
        checks++;
        if (alct_sync_req !== 1'b0) begin errors++; $display("FAIL done_drop_sync_req: got %b expected 0", alct_sync_req); end
        checks++;
        if ({alct_lost_cnt, alct_retry_cnt} !== {8'd1, 2'd0}) begin
            errors++; $display("FAIL done_drop_counts: got lost=%0d retry=%0d expected lost=1 retry=0", alct_lost_cnt, alct_retry_cnt);
        end
        $display("test_done_drop: sync_req=%b lost=%0d", alct_sync_req, alct_lost_cnt);
    endtask

    task automatic test_async_reset();
        int s, l, exp_l;
        repeat (5) step(1'b0, 28'd0);
        fill_sync(60);
        exp_l = predict_link();
        play_stream(150, s, l);
        checks++;
        if (l !== exp_l) begin errors++; $display("FAIL rst_setup_link_up: got %0d expected %0d", l, exp_l); end
        #2;
        global_reset = 1'b1;
        #1;
        checks++;
        if (alct_link_up !== 1'b0) begin errors++; $display("FAIL async_rst_link_up: got %b expected 0", alct_link_up); end
        checks++;
        if ({alct_sync_req, alct_link_fail, alct_retry_cnt, alct_lost_cnt} !== 12'd0) begin
            errors++; $display("FAIL async_rst_others: got sync=%b fail=%b retry=%0d lost=%0d expected all 0",
                               alct_sync_req, alct_link_fail, alct_retry_cnt, alct_lost_cnt);
        end
        @(negedge clock);
        global_reset = 1'b0;
        @(negedge clock);
        $display("test_async_reset: outputs cleared without a clock edge");
    endtask

    initial begin
        test_reset();
        test_bringup_basic();
        test_mismatch_run();
        test_alt_valid();
        test_random();
        test_retry_fail();
        test_link_lost();
        test_done_drop();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, got no completion expected completion");
        $fatal(1, "watchdog");
    end
endmodule
